moore_seq_det: RTL and testbench



---
 rtl/moore_seq_det.sv | 106 ++++++++++
 tb/tb_moore_seq_det.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial sequence detector tracking matched pattern prefix length k.
// Optional saturating hit counter enabled by defining MOORE_SEQ_DET_HIT_COUNT_EN.
module moore_seq_det #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
  parameter int              CNT_W   = 8,
`endif
  parameter int              STW     = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             OVERLAP,
  input  logic             X,
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
  output logic [CNT_W-1:0] HIT_CNT,
`endif
  output logic             Z,
  output logic [STW-1:0]   STATE
);

  typedef enum logic [1:0] {
    ST_IDLE_HOLD = 2'd0,
    ST_ADVANCE   = 2'd1,
    ST_FALLBACK  = 2'd2,
    ST_RESTART   = 2'd3
  } step_e;

  logic [STW-1:0] k_q, k_d;
  step_e          step;

  // Longest proper suffix of (PATTERN[first k bits], x) that is also a pattern prefix.
  function automatic int kmp_fallback(input int k, input logic x);
    int   best;
    int   idx;
    logic ok;
    logic hb;
    best = 0;
    for (int l = 1; l <= WIDTH; l++) begin
      if (l <= k) begin
        ok = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
          if (j < l) begin
            idx = k + 1 - l + j;
            hb  = (idx == k) ? x : PATTERN[WIDTH-1-idx];
            if (hb != PATTERN[WIDTH-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  int   k_int;
  logic expect_bit;

  always_comb begin
    k_int      = int'(k_q);
    expect_bit = 1'b0;
    if (k_int < WIDTH) expect_bit = PATTERN[WIDTH-1-k_int];

    step = ST_IDLE_HOLD;
    if (EN) begin
      if (k_int < WIDTH && X == expect_bit) step = ST_ADVANCE;
      else if (k_int == WIDTH && !OVERLAP)  step = ST_RESTART;
      else                                  step = ST_FALLBACK;
    end

    k_d = k_q;
    case (step)
      ST_ADVANCE:  k_d = STW'(k_int + 1);
      ST_FALLBACK: k_d = STW'(kmp_fallback(k_int, X));
      ST_RESTART:  k_d = (X == PATTERN[WIDTH-1]) ? STW'(1) : STW'(0);
      default:     k_d = k_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) k_q <= '0;
    else       k_q <= k_d;
  end

  assign STATE = k_q;
  assign Z     = (k_q == STW'(WIDTH));

`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  // Every accepted bit that lands in MATCH is one detection; EN=0 dwell does not count.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (EN && k_d == STW'(WIDTH) && hit_cnt_q != {CNT_W{1'b1}})
      hit_cnt_d = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) hit_cnt_q <= '0;
    else       hit_cnt_q <= hit_cnt_d;
  end

  assign HIT_CNT = hit_cnt_q;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed self-checking bench for moore_seq_det: pattern 1011 DUT plus a 1111 DUT for degenerate cases.
module tb_moore_seq_det;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ovl;
  logic       x;
  logic       z_a, z_b;
  logic [2:0] st_a, st_b;
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
  logic [7:0] hit_a;
  logic [1:0] hit_b;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  moore_seq_det #(.WIDTH(4), .PATTERN(4'b1011)) dut_a (
    .CLK(clk), .RESET(rst), .EN(en), .OVERLAP(ovl), .X(x),
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
    .HIT_CNT(hit_a),
`endif
    .Z(z_a), .STATE(st_a)
  );

  moore_seq_det #(
    .WIDTH(4), .PATTERN(4'b1111)
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut_b (
    .CLK(clk), .RESET(rst), .EN(en), .OVERLAP(ovl), .X(x),
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
    .HIT_CNT(hit_b),
`endif
    .Z(z_b), .STATE(st_b)
  );

  task automatic step(input logic e, input logic b);
    en = e;
    x  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; x = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (st_a !== 3'd0 || z_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: STATE=%0d Z=%b required STATE=0 Z=0", st_a, z_a);
    end
    checks++;
    if (st_b !== 3'd0 || z_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: STATE=%0d Z=%b required STATE=0 Z=0", st_b, z_b);
    end
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
    checks++;
    if (hit_a !== 8'd0 || hit_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_hit: HIT_CNT a=%0d b=%0d required 0", hit_a, hit_b);
    end
`endif
    $display("test_reset done: STATE=%0d Z=%b", st_a, z_a);
  endtask

  task automatic run_stream(input string name, input logic o, input int n,
                            input logic [15:0] bits, input logic [47:0] exp_st);
    logic [2:0] e;
    ovl = o;
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[i]);
      e = exp_st[3*i +: 3];
      checks++;
      if (st_a !== e || z_a !== (e == 3'd4)) begin
        failures++;
        $display("FAIL %s bit%0d: STATE=%0d Z=%b required STATE=%0d Z=%b",
                 name, i + 1, st_a, z_a, e, (e == 3'd4));
      end
      $display("%s bit%0d X=%b STATE=%0d Z=%b", name, i + 1, bits[i], st_a, z_a);
    end
  endtask

  // Bits listed LSB-first (bit index = stream position); states packed 3 bits each.
  task automatic test_overlap();
    test_reset();
    run_stream("overlap", 1'b1, 7, 16'b1101101,
               {3'd4, 3'd3, 3'd2, 3'd4, 3'd3, 3'd2, 3'd1});
  endtask

  task automatic test_no_overlap();
    test_reset();
    run_stream("no_overlap", 1'b0, 7, 16'b1101101,
               {3'd1, 3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1});
  endtask

  task automatic test_kmp_fallback();
    test_reset();
    run_stream("kmp", 1'b1, 6, 16'b110101,
               {3'd4, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1});
  endtask

  task automatic test_enable_hold();
    test_reset();
    run_stream("en_pre", 1'b1, 3, 16'b101, {3'd3, 3'd2, 3'd1});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0]);
      checks++;
      if (st_a !== 3'd3 || z_a !== 1'b0) begin
        failures++;
        $display("FAIL en_hold%0d: STATE=%0d Z=%b required STATE=3 Z=0", i, st_a, z_a);
      end
      $display("en_hold%0d STATE=%0d Z=%b", i, st_a, z_a);
    end
    step(1'b1, 1'b1);
    checks++;
    if (st_a !== 3'd4 || z_a !== 1'b1) begin
      failures++;
      $display("FAIL en_resume: STATE=%0d Z=%b required STATE=4 Z=1", st_a, z_a);
    end
    $display("en_resume STATE=%0d Z=%b", st_a, z_a);
    // EN=0 in MATCH keeps Z high
    step(1'b0, 1'b0);
    checks++;
    if (st_a !== 3'd4 || z_a !== 1'b1) begin
      failures++;
      $display("FAIL en_match_hold: STATE=%0d Z=%b required STATE=4 Z=1", st_a, z_a);
    end
    $display("en_match_hold STATE=%0d Z=%b", st_a, z_a);
  endtask

  task automatic test_reset_priority();
    test_reset();
    run_stream("rst_pre", 1'b1, 3, 16'b101, {3'd3, 3'd2, 3'd1});
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if (st_a !== 3'd0 || z_a !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority: STATE=%0d Z=%b required STATE=0 Z=0", st_a, z_a);
    end
    $display("rst_priority STATE=%0d Z=%b", st_a, z_a);
  endtask

  task automatic test_all_ones();
    int zc;
    int e;
    test_reset();
    ovl = 1'b0;
    zc  = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1);
      e = ((i - 1) % 4) + 1;
      if (z_b) zc++;
      checks++;
      if (int'(st_b) != e) begin
        failures++;
        $display("FAIL ones_noovl bit%0d: STATE=%0d required %0d", i, st_b, e);
      end
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
      if (i == 8) begin
        checks++;
        if (hit_b !== 2'd2) begin
          failures++;
          $display("FAIL hit_mid: HIT_CNT=%0d required 2", hit_b);
        end
      end
`endif
      $display("ones_noovl bit%0d STATE=%0d Z=%b", i, st_b, z_b);
    end
    checks++;
    if (zc != 5) begin
      failures++;
      $display("FAIL ones_noovl_count: Z cycles=%0d required 5", zc);
    end
`ifdef MOORE_SEQ_DET_HIT_COUNT_EN
    checks++;
    if (hit_b !== 2'd3) begin
      failures++;
      $display("FAIL hit_sat: HIT_CNT=%0d required 3", hit_b);
    end
`endif
    test_reset();
    ovl = 1'b1;
    zc  = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (z_b) zc++;
      $display("ones_ovl bit%0d STATE=%0d Z=%b", i, st_b, z_b);
    end
    checks++;
    if (zc != 7 || z_b !== 1'b1) begin
      failures++;
      $display("FAIL ones_ovl_count: Z cycles=%0d Z=%b required 7 and Z=1", zc, z_b);
    end
    // A 0 out of MATCH drops all the way back to 0
    step(1'b1, 1'b0);
    checks++;
    if (st_b !== 3'd0 || z_b !== 1'b0) begin
      failures++;
      $display("FAIL ones_break: STATE=%0d Z=%b required STATE=0 Z=0", st_b, z_b);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ovl = 1'b1; x = 1'b0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_kmp_fallback();
    test_enable_hold();
    test_reset_priority();
    test_all_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
